// File: rtl/sent_rx_pkg.sv
// Shared constants and slow-channel FSM encoding for the SENT RX frame buffer.
package sent_rx_pkg;

  localparam int FAST_W  = 12;
  localparam int ID_W    = 8;
  localparam int SDATA_W = 16;

  typedef logic [0:0] slow_state_t;
  localparam slow_state_t SLOW_IDLE    = 1'b0;
  localparam slow_state_t SLOW_PENDING = 1'b1;

endpackage

// File: rtl/sent_rx_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module sent_rx_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop frees the slot in the same edge, so a full FIFO still accepts a write alongside a read.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sent_rx_frame_buffer.sv
// SENT RX host-side buffer: fast-word FIFO, latest-wins slow message register, sticky loss status.
// Optional per-entry timestamps are built when SENT_RX_TIMESTAMP_EN is defined.
module sent_rx_frame_buffer
  import sent_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVF_W = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk_rx,
  input  logic                     reset_rx,
  input  logic                     write_enable_rx,
  input  logic [FAST_W-1:0]        data_to_fifo_rx,
  input  logic [ID_W-1:0]          id_received,
  input  logic [SDATA_W-1:0]       data_received,
  output logic                     fast_valid,
  input  logic                     fast_ready,
  output logic [FAST_W-1:0]        fast_data,
  output logic [$clog2(DEPTH):0]   fast_count,
`ifdef SENT_RX_TIMESTAMP_EN
  output logic [TS_W-1:0]          fast_timestamp,
`endif
  output logic                     slow_valid,
  input  logic                     slow_ack,
  output logic [ID_W-1:0]          slow_id,
  output logic [SDATA_W-1:0]       slow_data,
  input  logic                     clear_status,
  output logic                     fast_overflow,
  output logic [OVF_W-1:0]         overflow_count,
  output logic                     slow_lost,
  output slow_state_t              slow_state
);

`ifdef SENT_RX_TIMESTAMP_EN
  localparam int FIFO_W = FAST_W + TS_W;
  localparam logic [TS_W-1:0] TS_ONE = 1;
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk_rx) begin
    if (reset_rx) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + TS_ONE;
  end
`else
  localparam int FIFO_W = FAST_W;
`endif

  localparam logic [OVF_W-1:0] OVF_ONE = 1;

  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              ovf_evt;

`ifdef SENT_RX_TIMESTAMP_EN
  assign fifo_wdata     = {ts_cnt, data_to_fifo_rx};
  assign fast_timestamp = fast_valid ? fifo_rdata[FIFO_W-1:FAST_W] : '0;
`else
  assign fifo_wdata = data_to_fifo_rx;
`endif

  sent_rx_sync_fifo #(.WIDTH(FIFO_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk_rx),
    .rst     (reset_rx),
    .wr_en   (write_enable_rx),
    .wr_data (fifo_wdata),
    .rd_en   (fast_ready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fast_count)
  );

  assign fast_valid = !fifo_empty;
  // Memory is not reset, so mask the head while empty to keep the output at zero.
  assign fast_data  = fast_valid ? fifo_rdata[FAST_W-1:0] : '0;
  assign pop        = fast_valid && fast_ready;
  assign ovf_evt    = write_enable_rx && fifo_full && !pop;

  // Slow channel: capture whenever the decoder's level differs from the last captured message.
  logic [ID_W+SDATA_W-1:0] slow_ref;
  logic                    new_msg;
  logic                    loss_evt;

  assign new_msg    = ({id_received, data_received} != slow_ref);
  assign loss_evt   = (slow_state == SLOW_PENDING) && new_msg && !slow_ack;
  assign slow_valid = (slow_state == SLOW_PENDING);

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      slow_state <= SLOW_IDLE;
      slow_ref   <= '0;
      slow_id    <= '0;
      slow_data  <= '0;
    end else begin
      if (new_msg) begin
        slow_ref  <= {id_received, data_received};
        slow_id   <= id_received;
        slow_data <= data_received;
      end
      case (slow_state)
        SLOW_IDLE:    if (new_msg) slow_state <= SLOW_PENDING;
        SLOW_PENDING: if (slow_ack && !new_msg) slow_state <= SLOW_IDLE;
        default:      slow_state <= SLOW_IDLE;
      endcase
    end
  end

  // Status: an event in the same cycle as clear_status wins over the clear.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      fast_overflow  <= 1'b0;
      overflow_count <= '0;
      slow_lost      <= 1'b0;
    end else begin
      if (ovf_evt) begin
        fast_overflow <= 1'b1;
        if (clear_status)         overflow_count <= OVF_ONE;
        else if (!(&overflow_count)) overflow_count <= overflow_count + OVF_ONE;
      end else if (clear_status) begin
        fast_overflow  <= 1'b0;
        overflow_count <= '0;
      end
      if (loss_evt)          slow_lost <= 1'b1;
      else if (clear_status) slow_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sent_rx_frame_buffer.sv
// Directed bench for sent_rx_frame_buffer: expected-queue scoreboard on both readout handshakes.
// Build with SENT_RX_TIMESTAMP_EN to also exercise per-entry timestamps.
module tb_sent_rx_frame_buffer;
  import sent_rx_pkg::*;

  localparam int DEPTH = 16;
  localparam int OVF_W = 8;
  localparam int TS_W  = 16;

  logic              clk_rx = 1'b0;
  logic              reset_rx;
  logic              write_enable_rx;
  logic [11:0]       data_to_fifo_rx;
  logic [7:0]        id_received;
  logic [15:0]       data_received;
  logic              fast_valid;
  logic              fast_ready;
  logic [11:0]       fast_data;
  logic [4:0]        fast_count;
`ifdef SENT_RX_TIMESTAMP_EN
  logic [TS_W-1:0]   fast_timestamp;
`endif
  logic              slow_valid;
  logic              slow_ack;
  logic [7:0]        slow_id;
  logic [15:0]       slow_data;
  logic              clear_status;
  logic              fast_overflow;
  logic [OVF_W-1:0]  overflow_count;
  logic              slow_lost;
  slow_state_t       slow_state;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [23:0] slow_q[$];

  sent_rx_frame_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W), .TS_W(TS_W)) dut (
    .clk_rx          (clk_rx),
    .reset_rx        (reset_rx),
    .write_enable_rx (write_enable_rx),
    .data_to_fifo_rx (data_to_fifo_rx),
    .id_received     (id_received),
    .data_received   (data_received),
    .fast_valid      (fast_valid),
    .fast_ready      (fast_ready),
    .fast_data       (fast_data),
    .fast_count      (fast_count),
`ifdef SENT_RX_TIMESTAMP_EN
    .fast_timestamp  (fast_timestamp),
`endif
    .slow_valid      (slow_valid),
    .slow_ack        (slow_ack),
    .slow_id         (slow_id),
    .slow_data       (slow_data),
    .clear_status    (clear_status),
    .fast_overflow   (fast_overflow),
    .overflow_count  (overflow_count),
    .slow_lost       (slow_lost),
    .slow_state      (slow_state)
  );

  // Clock/reset block
  always #5 clk_rx = ~clk_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  task automatic write_word(input logic [11:0] w, input bit expect_store);
    write_enable_rx = 1'b1;
    data_to_fifo_rx = w;
    if (expect_store) exp_q.push_back(w);
    step();
    write_enable_rx = 1'b0;
  endtask

  task automatic set_slow(input logic [7:0] id, input logic [15:0] d);
    id_received   = id;
    data_received = d;
  endtask

  // Scoreboard monitor: a transfer is committed at the next rising edge.
  always @(negedge clk_rx) begin
    if (!reset_rx && fast_valid && fast_ready) begin
      if (exp_q.size() == 0) check("fast_pop_unexpected", 32'(fast_data), 32'hFFFF_FFFF);
      else check("fast_pop_data", 32'(fast_data), 32'(exp_q.pop_front()));
    end
    if (!reset_rx && slow_valid && slow_ack) begin
      if (slow_q.size() == 0) check("slow_ack_unexpected", {8'h0, slow_id, slow_data}, 32'hFFFF_FFFF);
      else check("slow_ack_msg", {8'h0, slow_id, slow_data}, {8'h0, slow_q.pop_front()});
    end
  end

  initial begin
    reset_rx = 1'b1; write_enable_rx = 1'b0; data_to_fifo_rx = '0;
    set_slow(8'h00, 16'h0000);
    fast_ready = 1'b0; slow_ack = 1'b0; clear_status = 1'b0;
    step(3);
    reset_rx = 1'b0;
    step();

    // Reset state: all-zero decoder level matches the reference, so nothing is captured.
    check("rst_fast_valid", 32'(fast_valid), 0);
    check("rst_fast_count", 32'(fast_count), 0);
    check("rst_fast_data", 32'(fast_data), 0);
    check("rst_slow_valid", 32'(slow_valid), 0);
    check("rst_status", {29'h0, fast_overflow, slow_lost, slow_state}, 0);
    check("rst_ovf_count", 32'(overflow_count), 0);

    // 1: two writes, show-ahead head, two pops
    write_word(12'hA5C, 1'b1);
    write_word(12'h123, 1'b1);
    check("t1_count2", 32'(fast_count), 2);
    check("t1_head", 32'(fast_data), 32'hA5C);
    fast_ready = 1'b1;
    step(2);
    fast_ready = 1'b0;
    check("t1_valid_empty", 32'(fast_valid), 0);
    check("t1_count0", 32'(fast_count), 0);
    fast_ready = 1'b1;
    step();
    fast_ready = 1'b0;
    check("t1_ready_empty_ignored", 32'(fast_count), 0);

    // 2: 17 writes into a 16-deep FIFO, then saturate the counter
    for (int i = 0; i < 17; i++) write_word(12'h100 + 12'(i), i < 16);
    check("t2_count_full", 32'(fast_count), 16);
    check("t2_overflow", 32'(fast_overflow), 1);
    check("t2_ovf_count1", 32'(overflow_count), 1);
    check("t2_head_first", 32'(fast_data), 32'h100);
    for (int i = 0; i < 300; i++) write_word(12'hEEE, 1'b0);
    check("t2_ovf_saturated", 32'(overflow_count), 255);
    check("t2_count_still_full", 32'(fast_count), 16);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("t2_clear_flag", 32'(fast_overflow), 0);
    check("t2_clear_count", 32'(overflow_count), 0);

    // 3: full FIFO, write and pop in the same cycle
    fast_ready = 1'b1;
    write_word(12'h777, 1'b1);
    fast_ready = 1'b0;
    check("t3_count_16", 32'(fast_count), 16);
    check("t3_no_overflow", 32'(fast_overflow), 0);
    check("t3_ovf_count0", 32'(overflow_count), 0);
    fast_ready = 1'b1;
    step(16);
    fast_ready = 1'b0;
    check("t3_drained", 32'(fast_count), 0);

    // 4: slow message, overwrite before ack, ack, repeated level
    set_slow(8'h03, 16'hBEEF);
    step();
    check("t4_valid", 32'(slow_valid), 1);
    check("t4_msg", {8'h0, slow_id, slow_data}, 32'h0003BEEF);
    set_slow(8'h04, 16'hBEEF);
    step();
    check("t4_overwrite_id", 32'(slow_id), 32'h04);
    check("t4_lost", 32'(slow_lost), 1);
    slow_q.push_back({8'h04, 16'hBEEF});
    slow_ack = 1'b1;
    step();
    slow_ack = 1'b0;
    check("t4_acked", 32'(slow_valid), 0);
    step(3);
    check("t4_no_recapture", 32'(slow_valid), 0);
    slow_ack = 1'b1;
    step();
    slow_ack = 1'b0;
    check("t4_ack_idle_ignored", 32'(slow_state), 32'(SLOW_IDLE));

    // 5: ack coincident with a new message
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("t5_lost_cleared", 32'(slow_lost), 0);
    set_slow(8'h05, 16'h1111);
    step();
    slow_q.push_back({8'h05, 16'h1111});
    slow_ack = 1'b1;
    set_slow(8'h07, 16'h2222);
    step();
    slow_ack = 1'b0;
    check("t5_still_valid", 32'(slow_valid), 1);
    check("t5_msg", {8'h0, slow_id, slow_data}, 32'h00072222);
    check("t5_no_loss", 32'(slow_lost), 0);

    // 6: clear_status coincident with an overflow write
    for (int i = 0; i < 16; i++) write_word(12'h200 + 12'(i), 1'b1);
    write_word(12'hBAD, 1'b0);
    write_word(12'hBAD, 1'b0);
    check("t6_ovf_count2", 32'(overflow_count), 2);
    clear_status = 1'b1;
    write_word(12'hBAD, 1'b0);
    clear_status = 1'b0;
    check("t6_clear_vs_event_flag", 32'(fast_overflow), 1);
    check("t6_clear_vs_event_count", 32'(overflow_count), 1);

    // 6: mid-operation reset with FIFO full and a slow message pending
    reset_rx = 1'b1;
    set_slow(8'h00, 16'h0000);
    step();
    exp_q.delete();
    slow_q.delete();
    check("t6_rst_fast", {fast_valid, 7'h0, 3'h0, fast_count, 4'h0, fast_data}, 0);
    check("t6_rst_slow", {7'h0, slow_valid, slow_id, slow_data}, 0);
    check("t6_rst_status", {22'h0, overflow_count, fast_overflow, slow_lost}, 0);
    reset_rx = 1'b0;
    step();
    check("t6_post_rst_state", 32'(slow_state), 32'(SLOW_IDLE));

`ifdef SENT_RX_TIMESTAMP_EN
    begin
      logic [TS_W-1:0] t1;
      write_word(12'h0AA, 1'b1);
      t1 = fast_timestamp;
      step(4);
      write_word(12'h0BB, 1'b1);
      fast_ready = 1'b1;
      step();
      fast_ready = 1'b0;
      check("ts_delta5", 32'(fast_timestamp), 32'(t1 + TS_W'(5)));
    end
`endif

    // Boundary data values, then drain everything with a bounded wait
    write_word(12'hFFF, 1'b1);
    write_word(12'h000, 1'b1);
    fast_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    fast_ready = 1'b0;
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_slow_queue_empty", 32'(slow_q.size()), 0);
    check("final_fifo_empty", 32'(fast_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
